// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 64'h0;
    localparam logic [XLEN-1:0] EXC_VEC  = 64'hD8;

    typedef enum logic [2:0] {
        PC_EXC,
        PC_ERET,
        PC_BR,
        PC_HOLD,
        PC_SEQ
    } pc_sel_e;

    typedef enum logic {
        BOOT,
        RUN
    } fetch_state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } if_id_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC priority encoder: exception > ERET > branch > stall > sequential.
module fetch_pc_sel
    import fetch_pkg::*;
#(
    parameter int unsigned   N       = fetch_pkg::XLEN,
    parameter logic [N-1:0]  EXC_VEC = fetch_pkg::EXC_VEC
) (
    input  logic         exc,
    input  logic         eret,
    input  logic         br_taken,
    input  logic         stall,
    input  logic [N-1:0] br_target,
    input  logic [N-1:0] elr,
    input  logic [N-1:0] pc,
    output pc_sel_e      sel,
    output logic [N-1:0] next_pc,
    output logic         misaligned
);

    logic [N-1:0] target;

    always_comb begin
        sel    = PC_SEQ;
        target = '0;
        if (exc) begin
            sel    = PC_EXC;
            target = EXC_VEC;
        end else if (eret) begin
            sel    = PC_ERET;
            target = elr;
        end else if (br_taken) begin
            sel    = PC_BR;
            target = br_target;
        end else if (stall) begin
            sel    = PC_HOLD;
        end
    end

    // Redirect targets are word-aligned here; the dropped low bits are reported
    // so the top can raise a fault for that redirect.
    always_comb begin
        next_pc    = pc + N'(4);
        misaligned = 1'b0;
        case (sel)
            PC_EXC, PC_ERET, PC_BR: begin
                next_pc    = {target[N-1:2], 2'b00};
                misaligned = |target[1:0];
            end
            PC_HOLD: next_pc = pc;
            default: next_pc = pc + N'(4);
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, BOOT/RUN sequencing, IF/ID register and fetch-fault reporting.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned  N        = fetch_pkg::XLEN,
    parameter int unsigned  IW       = fetch_pkg::ILEN,
    parameter int unsigned  AW       = 7,
    parameter logic [N-1:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter logic [N-1:0] EXC_VEC  = fetch_pkg::EXC_VEC
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          stall_i,
    input  logic          br_taken_i,
    input  logic [N-1:0]  br_target_i,
    input  logic          exc_i,
    input  logic          eret_i,
    input  logic [N-1:0]  elr_i,
    output logic [AW-1:0] imem_addr_o,
    input  logic [IW-1:0] imem_q_i,
    output logic          if_id_valid_o,
    output logic [N-1:0]  if_id_pc_o,
    output logic [IW-1:0] if_id_instr_o,
    output logic [N-1:0]  pc_o,
    output logic          fault_o
);

    fetch_state_e state, state_d;
    logic [N-1:0] pc, pc_d;
    if_id_t       if_id, if_id_d;
    logic         fault, fault_d;
    logic         oor_flag, oor_flag_d;

    pc_sel_e      sel;
    logic [N-1:0] next_pc;
    logic         misaligned;
    logic         redirect;
    logic         oor;
    logic         pc_load;

    fetch_pc_sel #(
        .N       (N),
        .EXC_VEC (EXC_VEC)
    ) u_pc_sel (
        .exc        (exc_i),
        .eret       (eret_i),
        .br_taken   (br_taken_i),
        .stall      (stall_i),
        .br_target  (br_target_i),
        .elr        (elr_i),
        .pc         (pc),
        .sel        (sel),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    assign redirect = (sel == PC_EXC) || (sel == PC_ERET) || (sel == PC_BR);
    assign oor      = |pc[N-1:AW+2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            if_id    <= '0;
            fault    <= 1'b0;
            oor_flag <= 1'b0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            if_id    <= if_id_d;
            fault    <= fault_d;
            oor_flag <= oor_flag_d;
        end
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        if_id_d = if_id;
        pc_load = 1'b0;
        // oor_flag remembers that the current (held) PC was already reported,
        // so a stalled out-of-range PC faults only once.
        fault_d = (redirect && misaligned) || (oor && !oor_flag);

        case (state)
            BOOT: begin
                state_d = RUN;
                if_id_d = '0;
                if (redirect) begin
                    pc_d    = next_pc;
                    pc_load = 1'b1;
                end
            end
            RUN: begin
                pc_d    = next_pc;
                pc_load = (sel != PC_HOLD);
                if (redirect) begin
                    if_id_d = '0;
                end else if (sel != PC_HOLD) begin
                    if_id_d.pc = pc;
                    if (oor) begin
                        if_id_d.valid = 1'b0;
                        if_id_d.instr = '0;
                    end else begin
                        if_id_d.valid = 1'b1;
                        if_id_d.instr = imem_q_i;
                    end
                end
            end
            default: begin
                state_d = BOOT;
                if_id_d = '0;
            end
        endcase

        oor_flag_d = pc_load ? 1'b0 : oor;
    end

    assign imem_addr_o   = pc[AW+1:2];
    assign pc_o          = pc;
    assign if_id_valid_o = if_id.valid;
    assign if_id_pc_o    = if_id.pc;
    assign if_id_instr_o = if_id.instr;
    assign fault_o       = fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a combinational ROM model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall_i, br_taken_i, exc_i, eret_i;
    logic [63:0] br_target_i, elr_i;
    logic [6:0]  imem_addr_o;
    logic [31:0] imem_q_i;
    logic        if_id_valid_o;
    logic [63:0] if_id_pc_o;
    logic [31:0] if_id_instr_o;
    logic [63:0] pc_o;
    logic        fault_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input int unsigned k);
        return 32'hE000_0000 + 32'(k);
    endfunction

    assign imem_q_i = rom(int'(imem_addr_o));

    fetch_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall_i       (stall_i),
        .br_taken_i    (br_taken_i),
        .br_target_i   (br_target_i),
        .exc_i         (exc_i),
        .eret_i        (eret_i),
        .elr_i         (elr_i),
        .imem_addr_o   (imem_addr_o),
        .imem_q_i      (imem_q_i),
        .if_id_valid_o (if_id_valid_o),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_instr_o (if_id_instr_o),
        .pc_o          (pc_o),
        .fault_o       (fault_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_i = 0; br_taken_i = 0; exc_i = 0; eret_i = 0;
        br_target_i = '0; elr_i = '0;
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [63:0] p, input logic [31:0] i);
        chk({tag, ".valid"}, 64'(if_id_valid_o), 64'(v));
        chk({tag, ".pc"}, if_id_pc_o, p);
        chk({tag, ".instr"}, 64'(if_id_instr_o), 64'(i));
    endtask

    initial begin
        reset_n = 0;
        idle();
        #12;
        chk_ifid("reset", 0, 64'h0, 32'h0);
        chk("reset.pc", pc_o, 64'h0);
        chk("reset.fault", 64'(fault_o), 64'h0);
        reset_n = 1;

        step();
        chk("boot.valid", 64'(if_id_valid_o), 64'h0);
        chk("boot.pc", pc_o, 64'h0);
        step();
        chk_ifid("first", 1, 64'h0, rom(0));
        chk("first.pc", pc_o, 64'h4);
        step();
        chk_ifid("second", 1, 64'h4, rom(1));
        chk("second.pc", pc_o, 64'h8);

        step();
        step();
        chk("pre_stall.pc", pc_o, 64'h10);
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.pc", pc_o, 64'h10);
            chk_ifid("stall", 1, 64'hC, rom(3));
        end
        stall_i = 0;
        step();
        chk_ifid("unstall", 1, 64'h10, rom(4));
        chk("unstall.pc", pc_o, 64'h14);

        br_taken_i = 1; br_target_i = 64'h08;
        step();
        chk("br8.pc", pc_o, 64'h08);
        chk("br8.valid", 64'(if_id_valid_o), 64'h0);
        br_target_i = 64'h20;
        step();
        chk("br20.pc", pc_o, 64'h20);
        chk_ifid("br20.flush", 0, 64'h0, 32'h0);
        idle();
        step();
        chk_ifid("br20.fetch", 1, 64'h20, rom(8));

        exc_i = 1; eret_i = 1; elr_i = 64'h1C; stall_i = 1;
        step();
        chk("exc.pc", pc_o, 64'hD8);
        chk_ifid("exc.flush", 0, 64'h0, 32'h0);
        idle();
        step();
        chk_ifid("exc.fetch", 1, 64'hD8, rom(54));
        chk("exc.next", pc_o, 64'hDC);

        eret_i = 1; elr_i = 64'h1C;
        step();
        chk("eret.pc", pc_o, 64'h1C);
        chk("eret.valid", 64'(if_id_valid_o), 64'h0);
        idle();
        step();
        chk_ifid("eret.fetch", 1, 64'h1C, rom(7));

        br_taken_i = 1; br_target_i = 64'h22;
        step();
        chk("misal.pc", pc_o, 64'h20);
        chk("misal.fault", 64'(fault_o), 64'h1);
        idle();
        step();
        chk("misal.fault_end", 64'(fault_o), 64'h0);
        chk_ifid("misal.fetch", 1, 64'h20, rom(8));

        br_taken_i = 1; br_target_i = 64'h200;
        step();
        chk("oor.pc", pc_o, 64'h200);
        chk("oor.fault_a", 64'(fault_o), 64'h0);
        chk("oor.valid_a", 64'(if_id_valid_o), 64'h0);
        idle();
        stall_i = 1;
        step();
        chk("oor.fault_b", 64'(fault_o), 64'h1);
        step();
        chk("oor.fault_c", 64'(fault_o), 64'h0);
        stall_i = 0;
        step();
        chk("oor.pc_d", pc_o, 64'h204);
        chk("oor.fault_d", 64'(fault_o), 64'h0);
        chk("oor.valid_d", 64'(if_id_valid_o), 64'h0);
        chk("oor.instr_d", 64'(if_id_instr_o), 64'h0);
        br_taken_i = 1; br_target_i = 64'h40;
        step();
        chk("oor.pc_e", pc_o, 64'h40);
        chk("oor.fault_e", 64'(fault_o), 64'h1);
        idle();

        #2 reset_n = 0;
        #1;
        chk_ifid("async_rst", 0, 64'h0, 32'h0);
        chk("async_rst.pc", pc_o, 64'h0);
        chk("async_rst.fault", 64'(fault_o), 64'h0);
        reset_n = 1;
        step();
        chk("rst_boot.valid", 64'(if_id_valid_o), 64'h0);
        chk("rst_boot.pc", pc_o, 64'h0);
        step();
        chk_ifid("rst_first", 1, 64'h0, rom(0));

        #2 reset_n = 0;
        #2 reset_n = 1;
        br_taken_i = 1; br_target_i = 64'h30;
        step();
        chk("bootbr.pc", pc_o, 64'h30);
        chk("bootbr.valid", 64'(if_id_valid_o), 64'h0);
        idle();
        step();
        chk_ifid("bootbr.fetch", 1, 64'h30, rom(12));
        chk("bootbr.next", pc_o, 64'h34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed no-finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
